// File: rtl/pid_plant_model_if.sv
// Bus between the PID controller and the plant model: actuator command in, measured feedback out.
interface pid_plant_model_if;
  logic       enable;
  logic [7:0] control_in;
  logic [7:0] disturbance;
  logic [7:0] feedback;
  logic       sample_valid;
  logic       busy;

  modport master (
    output enable, control_in, disturbance,
    input  feedback, sample_valid, busy
  );

  modport slave (
    input  enable, control_in, disturbance,
    output feedback, sample_valid, busy
  );
endinterface

// File: rtl/pid_plant_model.sv
// First-order lag plant with dead time and additive load disturbance; feedback lands 4 cycles after a tick.
// No backpressure: sample_valid is a one-cycle pulse the consumer must take when it fires.
module pid_plant_model #(
  parameter int DIV   = 4,
  parameter int SHIFT = 2,
  parameter int DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  pid_plant_model_if.slave  bus
);

  if (DIV < 4) begin : g_div_check
    $error("pid_plant_model: DIV must be >= 4");
  end
  if (SHIFT < 0 || SHIFT > 7) begin : g_shift_check
    $error("pid_plant_model: SHIFT must be in 0..7");
  end
  if (DELAY < 0 || DELAY > 7) begin : g_delay_check
    $error("pid_plant_model: DELAY must be in 0..7");
  end

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  // Keep at least one line entry so DELAY == 0 still elaborates; it is then simply never read.
  localparam int DL = (DELAY == 0) ? 1 : DELAY;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SAMPLE    = 2'd1,
    INTEGRATE = 2'd2,
    OUTPUT    = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        count;
  logic                 tick;
  logic [7:0]           line [DL];
  logic [7:0]           u_eff;
  logic [15:0]          y_acc;
  logic [7:0]           feedback;
  logic                 sample_valid;
  logic signed [16:0]   diff;
  logic signed [16:0]   step;
  logic signed [17:0]   y_sum;
  logic [15:0]          y_clamped;
  logic signed [9:0]    sum;
  logic [7:0]           sum_sat;

  assign tick = bus.enable && (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !bus.enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (tick) state_nxt = SAMPLE;
      SAMPLE:    state_nxt = INTEGRATE;
      INTEGRATE: state_nxt = OUTPUT;
      OUTPUT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Lag update in Q8.8; the floor of the arithmetic shift is what makes the rise stall just short of target.
  always_comb begin
    diff  = $signed({1'b0, u_eff, 8'h00}) - $signed({1'b0, y_acc});
    step  = diff >>> SHIFT;
    y_sum = $signed({2'b00, y_acc}) + $signed({step[16], step});
    if (y_sum[17]) begin
      y_clamped = 16'h0000;
    end else if (y_sum[16:0] > 17'h0FF00) begin
      y_clamped = 16'hFF00;
    end else begin
      y_clamped = y_sum[15:0];
    end
  end

  always_comb begin
    sum = $signed({2'b00, y_acc[15:8]}) + $signed({{2{bus.disturbance[7]}}, bus.disturbance});
    if (sum[9]) begin
      sum_sat = 8'h00;
    end else if (sum[8]) begin
      sum_sat = 8'hFF;
    end else begin
      sum_sat = sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_acc        <= '0;
      u_eff        <= '0;
      feedback     <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < DL; i++) begin
        line[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state)
        SAMPLE: begin
          u_eff   <= (DELAY == 0) ? bus.control_in : line[DL-1];
          line[0] <= bus.control_in;
          for (int i = 1; i < DL; i++) begin
            line[i] <= line[i-1];
          end
        end
        INTEGRATE: y_acc <= y_clamped;
        OUTPUT: begin
          feedback     <= sum_sat;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.feedback     = feedback;
  assign bus.sample_valid = sample_valid;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_pid_plant_model.sv
// Directed bench for pid_plant_model (DIV=4, SHIFT=2, DELAY=2) with hand-computed expectations.
module tb_pid_plant_model;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pid_plant_model_if bus ();

  pid_plant_model #(.DIV(4), .SHIFT(2), .DELAY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until sample_valid is seen; a missing pulse is itself a failed comparison.
  task automatic wait_pulse(input string tag, output int fb, output int cyc);
    int seen;
    seen = 0;
    cyc  = 0;
    fb   = -1;
    while (seen == 0 && cyc < 40) begin
      step_clk();
      cyc++;
      if (bus.sample_valid) begin
        seen = 1;
        fb   = int'(bus.feedback);
      end
    end
    chk({tag, "_seen"}, seen, 1);
  endtask

  task automatic run_updates(input int n, output int fb);
    int c;
    fb = -1;
    repeat (n) wait_pulse("run", fb, c);
  endtask

  // Step of 200 from a cleared plant: two dead-time samples, then y_acc 0x3200 and 0x5780.
  // The release edge counts as cycle 1, so the first pulse shows after the 7th clean edge (cycle 8).
  task automatic check_step(input string tag);
    int fb;
    int c;
    wait_pulse({tag, "_p1"}, fb, c);
    chk({tag, "_first_lat"}, c, 7);
    chk({tag, "_fb1"}, fb, 0);
    wait_pulse({tag, "_p2"}, fb, c);
    chk({tag, "_period"}, c, 4);
    chk({tag, "_fb2"}, fb, 0);
    wait_pulse({tag, "_p3"}, fb, c);
    chk({tag, "_fb3"}, fb, 50);
    wait_pulse({tag, "_p4"}, fb, c);
    chk({tag, "_fb4"}, fb, 87);
  endtask

  initial begin
    int fb;
    int c;
    int mn;
    int mx;
    int np;

    bus.enable      = 1'b1;
    bus.control_in  = 8'd123;
    bus.disturbance = 8'd5;
    rst             = 1'b1;
    repeat (3) step_clk();
    chk("reset_fb", int'(bus.feedback), 0);
    chk("reset_sv", int'(bus.sample_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);

    bus.control_in  = 8'd200;
    bus.disturbance = 8'd0;
    rst             = 1'b0;
    check_step("step1");

    // Rising toward 201 stalls 3 LSBs short: y_acc 0xC8FD, plant output 200.
    bus.control_in = 8'd201;
    run_updates(60, fb);
    chk("plant_200", fb, 200);
    bus.disturbance = 8'd100;
    wait_pulse("dist_hi", fb, c);
    chk("sat_hi", fb, 255);
    bus.disturbance = 8'd0;
    wait_pulse("dist_hi_off", fb, c);
    chk("y_kept_hi", fb, 200);

    // Falling toward 50 converges exactly: y_acc 0x3200.
    bus.control_in = 8'd50;
    run_updates(60, fb);
    chk("plant_50", fb, 50);
    bus.disturbance = 8'h80;
    wait_pulse("dist_lo", fb, c);
    chk("sat_lo", fb, 0);
    bus.disturbance = 8'd0;
    wait_pulse("dist_lo_off", fb, c);
    chk("y_kept_lo", fb, 50);

    bus.control_in = 8'd255;
    mn = 1000;
    mx = 0;
    for (int i = 0; i < 100; i++) begin
      wait_pulse("conv", fb, c);
      if (c < mn) mn = c;
      if (c > mx) mx = c;
      if (i >= 90) chk("conv_fb", fb, 254);
    end
    chk("conv_period_min", mn, 4);
    chk("conv_period_max", mx, 4);

    // Just after a pulse the FSM is in IDLE with a tick pending: two edges puts it in INTEGRATE.
    step_clk();
    step_clk();
    chk("gate_busy_integrate", int'(bus.busy), 1);
    bus.enable = 1'b0;
    wait_pulse("gate_pending", fb, c);
    chk("gate_pending_lat", c, 2);
    chk("gate_pending_fb", fb, 254);
    bus.control_in = 8'd0;
    np = 0;
    repeat (20) begin
      step_clk();
      if (bus.sample_valid) np++;
    end
    chk("gate_no_pulses", np, 0);
    chk("gate_idle_busy", int'(bus.busy), 0);
    chk("gate_fb_hold", int'(bus.feedback), 254);

    // Line still holds [255,255]: two more 254s, then u=0 pulls y_acc 0xFEFD -> 0xBF3D.
    bus.enable = 1'b1;
    wait_pulse("reen_p1", fb, c);
    chk("reen_lat", c, 7);
    chk("reen_fb1", fb, 254);
    wait_pulse("reen_p2", fb, c);
    chk("reen_fb2", fb, 254);
    wait_pulse("reen_p3", fb, c);
    chk("reen_fb3", fb, 191);

    bus.control_in = 8'd255;
    run_updates(2, fb);
    step_clk();
    step_clk();
    chk("rst_mid_busy", int'(bus.busy), 1);
    rst            = 1'b1;
    bus.control_in = 8'd200;
    step_clk();
    chk("rst_mid_fb", int'(bus.feedback), 0);
    chk("rst_mid_sv", int'(bus.sample_valid), 0);
    chk("rst_mid_busy0", int'(bus.busy), 0);
    step_clk();
    rst = 1'b0;
    check_step("step2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
